axi_lite_read_walker: RTL and testbench
=======================================

Name: axi_lite_read_walker

Overview:
- Parametrised AXI4-Lite read master. Issues a programmable sequence of single-beat reads and streams each returned word out.
- Two address modes:
  - pointer-chase: next address = returned data.
  - linear stride: next address = previous address + STRIDE.
- Start/count control, read-response error detection and a done pulse make it usable as a ROM/table walker under a controller, not only as a free-running bus exerciser.

Parameters:
- DATA_WIDTH, 32, width of r_data and out_data.
- ADDR_WIDTH, 10, width of ar_addr and start_addr.
- CNT_WIDTH, 8, width of the read-count field.
- STRIDE, 4, address increment in linear mode, ADDR_WIDTH-bit unsigned.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle request to begin a walk; sampled only in IDLE.
- mode, input, 1, 0 = chase, 1 = linear; captured on start.
- start_addr, input, ADDR_WIDTH, first read address; captured on start.
- count, input, CNT_WIDTH, number of reads; captured on start.
- busy, output, 1, high from the cycle after start acceptance until done.
- done, output, 1, one-cycle pulse at end of walk (normal, zero-count or error).
- err, output, 1, sticky; set on non-OKAY r_resp, cleared on next accepted start.
- out_valid, output, 1, one-cycle pulse per completed read beat.
- out_data, output, DATA_WIDTH, data of the current beat; valid only with out_valid.
- ar_valid, output, 1, AXI read-address valid.
- ar_ready, input, 1, AXI read-address ready.
- ar_addr, output, ADDR_WIDTH, AXI read address.
- r_valid, input, 1, AXI read-data valid.
- r_ready, output, 1, AXI read-data ready.
- r_data, input, DATA_WIDTH, AXI read data.
- r_resp, input, 2, AXI read response; 2'b00 = OKAY.

Behaviour:
- Reset (async, rst_n low): state = IDLE.
  - Outputs cleared: busy, done, err, out_valid, ar_valid, r_ready.
  - Registers cleared: ar_addr, out_data, internal addr, remaining count.
  - Reset mid-transaction abandons it immediately; no completion is emitted.
- States: IDLE, SEND_ADDR, WAIT_DATA. At most one outstanding transaction.
- IDLE: start=1 captures mode, start_addr and count.
  - count != 0: go to SEND_ADDR next cycle, busy=1, err cleared.
  - count == 0: stay IDLE, pulse done=1 next cycle, err cleared, no bus activity.
- SEND_ADDR:
  - ar_valid=1, ar_addr=internal addr, r_ready=0.
  - ar_addr must stay stable while ar_valid=1 and ar_ready=0.
  - On ar_valid && ar_ready at posedge, go to WAIT_DATA.
- WAIT_DATA:
  - ar_valid=0, ar_addr driven 0, r_ready=1.
  - On r_valid at posedge: out_valid=1 and out_data=r_data in the next cycle (registered, latency 1).
  - If r_resp != 2'b00: set err, go to IDLE, pulse done. Remaining reads are aborted and out_valid still pulses for the bad beat.
  - Otherwise decrement remaining count.
    - Remaining count reaches 0: go to IDLE, pulse done, busy falls in the same cycle as done.
    - Else load next addr and go to SEND_ADDR:
      - chase: r_data[ADDR_WIDTH-1:0], zero-extended if DATA_WIDTH < ADDR_WIDTH.
      - linear: addr + STRIDE, wrapping modulo 2^ADDR_WIDTH.
- r_valid arriving outside WAIT_DATA is not accepted (r_ready=0).
- start while busy is ignored; captured parameters do not change mid-walk.
- Minimum per-read latency with ar_ready and r_valid tied high: 2 cycles per read. Walk of N reads: done pulse 2N+1 cycles after start.
- An unreachable state returns to IDLE and asserts err.

Test Plan:
- Linear, start_addr=0x010, count=4, ROM returns addr+0x100, ar_ready/r_valid tied 1 -> ar_addr 0x010, 0x014, 0x018, 0x01C; out_data 0x110, 0x114, 0x118, 0x11C; done 9 cycles after start; err=0.
- Chase, start_addr=0x000, ROM[0]=0x008, ROM[8]=0x020, ROM[0x20]=0x3FC, count=3 -> ar_addr 0x000, 0x008, 0x020; out_data 0x008, 0x020, 0x3FC; done pulse.
- Backpressure: ar_ready low 3 cycles, r_valid delayed 2 cycles -> ar_addr stable while ar_valid=1, no extra out_valid, count honoured.
- Error: linear count=5, r_resp=2'b10 on 2nd beat -> 2 out_valid pulses, err=1, done pulse, no 3rd ar_valid; next start clears err.
- count=0 -> done pulses 1 cycle after start, ar_valid never rises, busy stays 0.
- Linear wrap: start_addr=0x3F8, STRIDE=4, count=3 -> ar_addr 0x3F8, 0x3FC, 0x000. Reset asserted mid-walk -> all outputs 0 immediately, IDLE afterwards.

Source files
------------

// File: rtl/axi_lite_read_walker.sv
// axi_lite_read_walker: AXI4-Lite read master that walks a pointer chain or a linear stride,
// streaming each returned word out with start/count control, error detection and a done pulse.
module axi_lite_read_walker #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 8,
  parameter int STRIDE     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [CNT_WIDTH-1:0]  count,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  output logic [ADDR_WIDTH-1:0] ar_addr,
  input  logic                  r_valid,
  output logic                  r_ready,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic [1:0]            r_resp
);
  typedef enum logic [1:0] {IDLE = 2'd0, SEND_ADDR = 2'd1, WAIT_DATA = 2'd2} state_t;
  state_t                r_state, w_state;
  logic                  r_mode, w_mode;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr, w_next_addr;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt;
  logic                  r_done, w_done;
  logic                  r_err, w_err;
  logic                  r_out_valid, w_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data, w_out_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mode      <= 1'b0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_state;
      r_mode      <= w_mode;
      r_addr      <= w_addr;
      r_cnt       <= w_cnt;
      r_done      <= w_done;
      r_err       <= w_err;
      r_out_valid <= w_out_valid;
      r_out_data  <= w_out_data;
    end
  end
  // chase takes the low address bits of the returned word; the size cast zero-extends narrow data
  assign w_next_addr = r_mode ? r_addr + ADDR_WIDTH'(STRIDE) : ADDR_WIDTH'(r_data);
  always_comb begin
    w_state     = r_state;
    w_mode      = r_mode;
    w_addr      = r_addr;
    w_cnt       = r_cnt;
    w_done      = 1'b0;
    w_err       = r_err;
    w_out_valid = 1'b0;
    w_out_data  = r_out_data;
    case (r_state)
      IDLE: if (start) begin
        w_mode  = mode;
        w_addr  = start_addr;
        w_cnt   = count;
        w_err   = 1'b0;
        w_done  = count == '0;
        w_state = count == '0 ? IDLE : SEND_ADDR;
      end
      SEND_ADDR: if (ar_ready) w_state = WAIT_DATA;
      WAIT_DATA: if (r_valid) begin
        w_out_valid = 1'b1;
        w_out_data  = r_data;
        w_cnt       = r_cnt - CNT_WIDTH'(1);
        if (r_resp != 2'b00) begin
          w_err   = 1'b1;
          w_done  = 1'b1;
          w_state = IDLE;
        end else if (r_cnt == CNT_WIDTH'(1)) begin
          w_done  = 1'b1;
          w_state = IDLE;
        end else begin
          w_addr  = w_next_addr;
          w_state = SEND_ADDR;
        end
      end
      default: begin
        w_state = IDLE;
        w_err   = 1'b1;
      end
    endcase
  end
  assign busy      = r_state != IDLE;
  assign ar_valid  = r_state == SEND_ADDR;
  assign ar_addr   = ar_valid ? r_addr : '0;
  assign r_ready   = r_state == WAIT_DATA;
  assign done      = r_done;
  assign err       = r_err;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
endmodule

// File: tb/tb_axi_lite_read_walker.sv
// tb_axi_lite_read_walker: directed bench with a ROM slave model and bus/output monitors.
module tb_axi_lite_read_walker;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
  logic [9:0]  start_addr = '0;
  logic [7:0]  count = '0;
  logic        busy, done, err, out_valid, ar_valid, ar_ready, r_valid, r_ready;
  logic [31:0] out_data, r_data;
  logic [9:0]  ar_addr;
  logic [1:0]  r_resp;
  int n_chk = 0, n_pass = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, busy_cyc = 0, arv_cyc = 0, unstable = 0, overlap = 0;
  int ar_n = 0, out_n = 0, ar_b = 0, out_b = 0, d0 = 0, st_cyc = 0;
  int ar_delay = 0, r_delay = 0, ar_wait = 0, r_wait = 0, r_beats = 0, beat_base = 0, err_beat = 0;
  int b0 = 0, a0 = 0;
  logic [9:0]  ar_log [256];
  logic [31:0] out_log [256];
  logic        pend = 1'b0, rom_sel = 1'b0, prev_wait = 1'b0;
  logic [9:0]  pend_addr = '0, prev_addr = '0;

  axi_lite_read_walker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .start_addr(start_addr), .count(count),
    .busy(busy), .done(done), .err(err), .out_valid(out_valid), .out_data(out_data),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [9:0] a, input logic sel);
    if (!sel) return {22'd0, a} + 32'h100;
    case (a)
      10'h000: return 32'h008;
      10'h008: return 32'h020;
      10'h020: return 32'h3FC;
      default: return 32'hDEAD0000 | {22'd0, a};
    endcase
  endfunction

  assign ar_ready = ar_wait >= ar_delay;
  assign r_valid  = pend && r_wait >= r_delay;
  assign r_data   = rom(pend_addr, rom_sel);
  assign r_resp   = (err_beat != 0 && r_beats - beat_base + 1 == err_beat) ? 2'b10 : 2'b00;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend    <= 1'b0;
      ar_wait <= 0;
      r_wait  <= 0;
    end else begin
      ar_wait <= (ar_valid && !ar_ready) ? ar_wait + 1 : 0;
      r_wait  <= (pend && !r_valid) ? r_wait + 1 : 0;
      if (ar_valid && ar_ready) begin
        pend      <= 1'b1;
        pend_addr <= ar_addr;
      end else if (r_valid && r_ready) begin
        pend    <= 1'b0;
        r_beats <= r_beats + 1;
      end
    end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n) begin
      if (ar_valid && ar_ready) begin
        ar_log[ar_n] = ar_addr;
        ar_n++;
      end
      if (prev_wait && (!ar_valid || ar_addr != prev_addr)) unstable++;
      prev_wait = ar_valid && !ar_ready;
      prev_addr = ar_addr;
      if (out_valid) begin
        out_log[out_n] = out_data;
        out_n++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cyc++;
      if (ar_valid) arv_cyc++;
      if (busy && done) overlap++;
    end else prev_wait = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic walk(input logic m, input logic [9:0] a, input logic [7:0] n);
    ar_b = ar_n;
    out_b = out_n;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; mode = m; start_addr = a; count = n;
    st_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 300 && done_cnt == d0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_ar_valid", 32'(ar_valid), 0);
    check("rst_r_ready", 32'(r_ready), 0);
    rst_n = 1'b1;

    walk(1'b1, 10'h010, 8'd4);
    check("lin_ar_n", 32'(ar_n - ar_b), 4);
    check("lin_out_n", 32'(out_n - out_b), 4);
    for (int i = 0; i < 4; i++) begin
      check("lin_ar", 32'(ar_log[ar_b + i]), 32'h010 + 32'(4 * i));
      check("lin_out", out_log[out_b + i], 32'h110 + 32'(4 * i));
    end
    check("lin_latency", 32'(done_cyc - st_cyc), 9);
    check("lin_done_n", 32'(done_cnt - d0), 1);
    check("lin_err", 32'(err), 0);

    rom_sel = 1'b1;
    walk(1'b0, 10'h000, 8'd3);
    check("chase_ar_n", 32'(ar_n - ar_b), 3);
    check("chase_ar0", 32'(ar_log[ar_b]), 32'h000);
    check("chase_ar1", 32'(ar_log[ar_b + 1]), 32'h008);
    check("chase_ar2", 32'(ar_log[ar_b + 2]), 32'h020);
    check("chase_out0", out_log[out_b], 32'h008);
    check("chase_out1", out_log[out_b + 1], 32'h020);
    check("chase_out2", out_log[out_b + 2], 32'h3FC);
    check("chase_done_n", 32'(done_cnt - d0), 1);
    rom_sel = 1'b0;

    ar_delay = 3;
    r_delay = 2;
    walk(1'b1, 10'h080, 8'd3);
    check("bp_ar_n", 32'(ar_n - ar_b), 3);
    check("bp_out_n", 32'(out_n - out_b), 3);
    check("bp_ar2", 32'(ar_log[ar_b + 2]), 32'h088);
    check("bp_out2", out_log[out_b + 2], 32'h188);
    check("bp_stable", 32'(unstable), 0);
    check("bp_latency", 32'(done_cyc - st_cyc), 22);
    ar_delay = 0;
    r_delay = 0;

    beat_base = r_beats;
    err_beat = 2;
    walk(1'b1, 10'h100, 8'd5);
    err_beat = 0;
    check("err_ar_n", 32'(ar_n - ar_b), 2);
    check("err_out_n", 32'(out_n - out_b), 2);
    check("err_out1", out_log[out_b + 1], 32'h204);
    check("err_flag", 32'(err), 1);
    check("err_done_n", 32'(done_cnt - d0), 1);
    walk(1'b1, 10'h040, 8'd1);
    check("err_clear", 32'(err), 0);
    check("err_next_out", out_log[out_b], 32'h140);

    b0 = busy_cyc;
    a0 = arv_cyc;
    walk(1'b1, 10'h010, 8'd0);
    check("zero_latency", 32'(done_cyc - st_cyc), 1);
    check("zero_done_n", 32'(done_cnt - d0), 1);
    check("zero_busy", 32'(busy_cyc - b0), 0);
    check("zero_ar_valid", 32'(arv_cyc - a0), 0);
    check("zero_out_n", 32'(out_n - out_b), 0);

    walk(1'b1, 10'h3F8, 8'd3);
    check("wrap_ar0", 32'(ar_log[ar_b]), 32'h3F8);
    check("wrap_ar1", 32'(ar_log[ar_b + 1]), 32'h3FC);
    check("wrap_ar2", 32'(ar_log[ar_b + 2]), 32'h000);
    check("wrap_out2", out_log[out_b + 2], 32'h100);

    r_delay = 2;
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b1; start_addr = 10'h010; count = 8'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ar_valid", 32'(ar_valid), 0);
    check("mid_rst_ar_addr", 32'(ar_addr), 0);
    check("mid_rst_r_ready", 32'(r_ready), 0);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_done", 32'(done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    b0 = busy_cyc;
    a0 = arv_cyc;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_busy", 32'(busy_cyc - b0), 0);
    check("post_rst_ar_valid", 32'(arv_cyc - a0), 0);
    r_delay = 0;
    walk(1'b1, 10'h020, 8'd1);
    check("post_rst_out_n", 32'(out_n - out_b), 1);
    check("post_rst_out", out_log[out_b], 32'h120);
    check("busy_done_overlap", 32'(overlap), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
